// File: rtl/load_store_unit_if.sv
// ---------------------------------------------------------------------------
// load_store_unit_if
// Data-memory bus between the load/store unit and the data memory.
// Single outstanding, word-addressed request with byte-lane enables.
//
// Signals:
//   mem_req    LSU -> mem  request, held until mem_ack
//   mem_we     LSU -> mem  1 = write
//   mem_addr   LSU -> mem  word-aligned byte address (ADDR_W bits)
//   mem_be     LSU -> mem  byte-lane enables, bit i covers [8i+7:8i]
//   mem_wdata  LSU -> mem  lane-replicated write data
//   mem_ack    mem -> LSU  request complete; read data valid this cycle
//   mem_rdata  mem -> LSU  read data
// Modports: master (LSU side), slave (memory side).
// ---------------------------------------------------------------------------
interface load_store_unit_if #(
    parameter int ADDR_W = 32
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_be;
    logic [31:0]       mem_wdata;
    logic              mem_ack;
    logic [31:0]       mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
// Memory-access stage after the ALU. Accepts RV32I load/store alucodes with
// the ALU's effective address, performs one data-memory access at a time
// (IDLE -> ACCESS -> DONE) and returns sign/zero-extended load data.
//
// Ports:
//   clk, rst_n       clock, synchronous active-low reset
//   in_valid_i       op offered this cycle
//   in_ready_o       unit idle and able to accept
//   alucode_i        6-bit ALU operation code (only LB..SW acted on)
//   addr_i           byte address
//   st_data_i        store data (rs2)
//   rd_i             load destination register
//   mem              data-memory bus (load_store_unit_if.master)
//   wb_valid_o       one-cycle pulse: load result on wb_data_o/wb_rd_o
//   wb_rd_o, wb_data_o  last completed load, held until the next one
//   st_done_o        one-cycle pulse: store completed
//   misalign_o       one-cycle pulse: misaligned op rejected
//                    (only when LSU_MISALIGN_TRAP_EN is defined)
//
// Build option: LSU_MISALIGN_TRAP_EN -- trap misaligned half/word accesses
// instead of silently aligning them.
// ---------------------------------------------------------------------------
module load_store_unit #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [5:0]        alucode_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       st_data_i,
    input  logic [4:0]        rd_i,
    load_store_unit_if.master mem,
    output logic              wb_valid_o,
    output logic [4:0]        wb_rd_o,
    output logic [31:0]       wb_data_o,
    output logic              st_done_o
`ifdef LSU_MISALIGN_TRAP_EN
    ,
    output logic              misalign_o
`endif
);
    // Memory alucodes, matching define.vh.
    localparam logic [5:0] ALU_LB  = 6'd9;
    localparam logic [5:0] ALU_LH  = 6'd10;
    localparam logic [5:0] ALU_LW  = 6'd11;
    localparam logic [5:0] ALU_LBU = 6'd12;
    localparam logic [5:0] ALU_LHU = 6'd13;
    localparam logic [5:0] ALU_SB  = 6'd14;
    localparam logic [5:0] ALU_SH  = 6'd15;
    localparam logic [5:0] ALU_SW  = 6'd16;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t state_q, state_d;

    logic              is_load_q, sign_q, trap_q, we_q;
    logic [1:0]        size_q, off_q;
    logic [4:0]        rd_q;
    logic [ADDR_W-1:0] addr_q;
    logic [3:0]        be_q;
    logic [31:0]       wdata_q;
    logic [31:0]       wb_data_q;
    logic [4:0]        wb_rd_q;

    logic       dec_mem, dec_load, dec_sign, dec_misal, trap_now, accept;
    logic [1:0] dec_size, off, off_eff;

    function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] o);
        case (size)
            SZ_B:    lane_be = 4'b0001 << o;
            SZ_H:    lane_be = o[1] ? 4'b1100 : 4'b0011;
            default: lane_be = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] d);
        case (size)
            SZ_B:    lane_wdata = {4{d[7:0]}};
            SZ_H:    lane_wdata = {2{d[15:0]}};
            default: lane_wdata = d;
        endcase
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] rdata, input logic [1:0] size,
                                                input logic sgn, input logic [1:0] o);
        logic [7:0]  b;
        logic [15:0] h;
        b = rdata[{o, 3'b000} +: 8];
        h = o[1] ? rdata[31:16] : rdata[15:0];
        case (size)
            SZ_B:    load_extend = {{24{sgn & b[7]}}, b};
            SZ_H:    load_extend = {{16{sgn & h[15]}}, h};
            default: load_extend = rdata;
        endcase
    endfunction

    // Op decode
    always_comb begin
        dec_mem  = 1'b1;
        dec_load = 1'b0;
        dec_sign = 1'b0;
        dec_size = SZ_W;
        case (alucode_i)
            ALU_LB:  begin dec_load = 1'b1; dec_size = SZ_B; dec_sign = 1'b1; end
            ALU_LH:  begin dec_load = 1'b1; dec_size = SZ_H; dec_sign = 1'b1; end
            ALU_LW:  begin dec_load = 1'b1; dec_size = SZ_W; end
            ALU_LBU: begin dec_load = 1'b1; dec_size = SZ_B; end
            ALU_LHU: begin dec_load = 1'b1; dec_size = SZ_H; end
            ALU_SB:  dec_size = SZ_B;
            ALU_SH:  dec_size = SZ_H;
            ALU_SW:  dec_size = SZ_W;
            default: dec_mem = 1'b0;
        endcase
    end

    assign off       = addr_i[1:0];
    assign dec_misal = ((dec_size == SZ_H) && off[0]) || ((dec_size == SZ_W) && (off != 2'b00));

`ifdef LSU_MISALIGN_TRAP_EN
    // Misaligned ops never reach memory, so the raw offset is always usable.
    assign trap_now = dec_misal;
    assign off_eff  = off;
`else
    // Misaligned ops are forced to natural alignment and proceed normally.
    assign trap_now = 1'b0;
    assign off_eff  = dec_misal ? ((dec_size == SZ_H) ? {off[1], 1'b0} : 2'b00) : off;
`endif

    // Next-state logic
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid_i && dec_mem) begin
                    accept  = 1'b1;
                    state_d = trap_now ? DONE : ACCESS;
                end
            end
            ACCESS:  if (mem.mem_ack) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            is_load_q <= 1'b0;
            sign_q    <= 1'b0;
            trap_q    <= 1'b0;
            we_q      <= 1'b0;
            size_q    <= SZ_W;
            off_q     <= 2'b00;
            rd_q      <= 5'd0;
            addr_q    <= '0;
            be_q      <= 4'b0000;
            wdata_q   <= 32'd0;
            wb_data_q <= 32'd0;
            wb_rd_q   <= 5'd0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                is_load_q <= dec_load;
                sign_q    <= dec_sign;
                size_q    <= dec_size;
                off_q     <= off_eff;
                rd_q      <= rd_i;
                trap_q    <= trap_now;
                // A trapped op leaves the bus registers untouched.
                if (!trap_now) begin
                    we_q    <= ~dec_load;
                    addr_q  <= {addr_i[ADDR_W-1:2], 2'b00};
                    be_q    <= lane_be(dec_size, off_eff);
                    wdata_q <= lane_wdata(dec_size, st_data_i);
                end
            end
            // Load result is captured on ack so it is visible in DONE and held after.
            if ((state_q == ACCESS) && mem.mem_ack && is_load_q) begin
                wb_data_q <= load_extend(mem.mem_rdata, size_q, sign_q, off_q);
                wb_rd_q   <= rd_q;
            end
        end
    end

    assign in_ready_o    = (state_q == IDLE);
    assign mem.mem_req   = (state_q == ACCESS);
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_be    = be_q;
    assign mem.mem_wdata = wdata_q;

    assign wb_valid_o = (state_q == DONE) && is_load_q && !trap_q;
    assign st_done_o  = (state_q == DONE) && !is_load_q && !trap_q;
    assign wb_data_o  = wb_data_q;
    assign wb_rd_o    = wb_rd_q;
`ifdef LSU_MISALIGN_TRAP_EN
    assign misalign_o = (state_q == DONE) && trap_q;
`endif
endmodule

// File: tb/tb_load_store_unit.sv
// ---------------------------------------------------------------------------
// tb_load_store_unit
// Self-checking bench for load_store_unit: directed cases followed by random
// load/store traffic checked against a byte-lane arithmetic reference model.
// Works in both builds (LSU_MISALIGN_TRAP_EN defined or not).
// ---------------------------------------------------------------------------
module tb_load_store_unit;
    localparam logic [5:0] ALU_LB  = 6'd9;
    localparam logic [5:0] ALU_LH  = 6'd10;
    localparam logic [5:0] ALU_LW  = 6'd11;
    localparam logic [5:0] ALU_LBU = 6'd12;
    localparam logic [5:0] ALU_LHU = 6'd13;
    localparam logic [5:0] ALU_SB  = 6'd14;
    localparam logic [5:0] ALU_SH  = 6'd15;
    localparam logic [5:0] ALU_SW  = 6'd16;
    localparam logic [5:0] ALU_ADD = 6'd17;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  alucode;
    logic [31:0] addr;
    logic [31:0] st_data;
    logic [4:0]  rd;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        st_done;
`ifdef LSU_MISALIGN_TRAP_EN
    logic        misalign;
`endif

    always #5 clk = ~clk;

    load_store_unit_if #(.ADDR_W(32)) mem_if ();

    load_store_unit #(.ADDR_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .alucode_i  (alucode),
        .addr_i     (addr),
        .st_data_i  (st_data),
        .rd_i       (rd),
        .mem        (mem_if.master),
        .wb_valid_o (wb_valid),
        .wb_rd_o    (wb_rd),
        .wb_data_o  (wb_data),
        .st_done_o  (st_done)
`ifdef LSU_MISALIGN_TRAP_EN
        ,
        .misalign_o (misalign)
`endif
    );

    int n_chk = 0;
    int n_bad = 0;

    logic [31:0] exp_wb_data = 32'd0;
    logic [4:0]  exp_wb_rd   = 5'd0;

    // Op presented upstream while the current one is still busy.
    logic [5:0]  nx_code;
    logic [31:0] nx_addr, nx_st;
    logic [4:0]  nx_rd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int nbytes(input logic [5:0] c);
        if (c == ALU_LB || c == ALU_LBU || c == ALU_SB) return 1;
        if (c == ALU_LH || c == ALU_LHU || c == ALU_SH) return 2;
        return 4;
    endfunction

    function automatic bit is_ld(input logic [5:0] c);
        return (c >= ALU_LB) && (c <= ALU_LHU);
    endfunction

    function automatic logic [31:0] ref_load(input logic [5:0] c, input logic [31:0] rdata, input int o);
        int     n;
        longint v;
        logic [63:0] t;
        n = nbytes(c);
        v = (longint'(rdata) >> (8 * o)) & ((64'd1 << (8 * n)) - 1);
        if ((c == ALU_LB || c == ALU_LH) && v >= (64'd1 << (8 * n - 1)))
            v = v - (64'd1 << (8 * n));
        t = v;
        return t[31:0];
    endfunction

    function automatic logic [3:0] ref_be(input int n, input int o);
        logic [31:0] t;
        t = ((32'd1 << n) - 1) << o;
        return t[3:0];
    endfunction

    function automatic logic [31:0] ref_wdata(input int n, input logic [31:0] d);
        logic [31:0] m, w;
        m = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 1);
        w = 32'd0;
        for (int i = 0; i < 4 / n; i++) w = w | ((d & m) << (8 * n * i));
        return w;
    endfunction

    // ---------------- one transaction ----------------
    task automatic run_op(input logic [5:0] c, input logic [31:0] a, input logic [31:0] st,
                          input logic [4:0] r, input int waits, input logic [31:0] rdata,
                          input bit hold_next);
        int guard;
        int n, oi, oe;
        bit mis, ld;
        guard = 0;
        in_valid = 1'b1; alucode = c; addr = a; st_data = st; rd = r;
        while (!in_ready && guard < 30) begin
            @(posedge clk); #1; guard++;
        end
        if (!in_ready) begin
            chk("ready_timeout", {31'd0, in_ready}, 32'd1);
            in_valid = 1'b0;
            return;
        end
        mem_if.mem_ack = 1'($urandom_range(0, 1));   // stray ack in IDLE is ignored
        @(posedge clk); #1;
        mem_if.mem_ack = 1'b0;
        if (hold_next) begin
            alucode = nx_code; addr = nx_addr; st_data = nx_st; rd = nx_rd;
        end else begin
            in_valid = 1'b0;
        end
        n   = nbytes(c);
        oi  = int'(a[1:0]);
        mis = (oi % n) != 0;
        oe  = oi - (oi % n);
        ld  = is_ld(c);
        chk("busy_acc", {31'd0, in_ready}, 32'd0);
`ifdef LSU_MISALIGN_TRAP_EN
        if (mis) begin
            chk("trap_req", {31'd0, mem_if.mem_req}, 32'd0);
            chk("trap_pulse", {31'd0, misalign}, 32'd1);
            chk("trap_wbv", {31'd0, wb_valid}, 32'd0);
            chk("trap_std", {31'd0, st_done}, 32'd0);
            chk("trap_wbdata", wb_data, exp_wb_data);
            @(posedge clk); #1;
            chk("trap_ready", {31'd0, in_ready}, 32'd1);
            chk("trap_clear", {31'd0, misalign}, 32'd0);
            return;
        end
        chk("no_trap", {31'd0, misalign}, 32'd0);
`endif
        chk("req", {31'd0, mem_if.mem_req}, 32'd1);
        chk("we", {31'd0, mem_if.mem_we}, {31'd0, !ld});
        chk("maddr", mem_if.mem_addr, {a[31:2], 2'b00});
        chk("be", {28'd0, mem_if.mem_be}, {28'd0, ref_be(n, oe)});
        if (!ld) chk("wdata", mem_if.mem_wdata, ref_wdata(n, st));
        for (int w = 0; w < waits; w++) begin
            @(posedge clk); #1;
            chk("req_hold", {31'd0, mem_if.mem_req}, 32'd1);
            chk("maddr_hold", mem_if.mem_addr, {a[31:2], 2'b00});
        end
        mem_if.mem_ack = 1'b1; mem_if.mem_rdata = rdata;
        @(posedge clk); #1;
        mem_if.mem_ack = 1'b0; mem_if.mem_rdata = $urandom;
        if (ld) begin
            exp_wb_data = ref_load(c, rdata, oe);
            exp_wb_rd   = r;
        end
        chk("wb_valid", {31'd0, wb_valid}, {31'd0, ld});
        chk("st_done", {31'd0, st_done}, {31'd0, !ld});
        chk("wb_data", wb_data, exp_wb_data);
        chk("wb_rd", {27'd0, wb_rd}, {27'd0, exp_wb_rd});
        chk("busy_done", {31'd0, in_ready}, 32'd0);
        chk("req_done", {31'd0, mem_if.mem_req}, 32'd0);
        mem_if.mem_ack = 1'($urandom_range(0, 1));   // stray ack in DONE is ignored
        @(posedge clk); #1;
        mem_if.mem_ack = 1'b0;
        chk("ready_back", {31'd0, in_ready}, 32'd1);
        chk("wbv_pulse", {31'd0, wb_valid}, 32'd0);
        chk("std_pulse", {31'd0, st_done}, 32'd0);
        chk("wb_hold", wb_data, exp_wb_data);
    endtask

    logic [5:0] codes [8] = '{ALU_LB, ALU_LH, ALU_LW, ALU_LBU, ALU_LHU, ALU_SB, ALU_SH, ALU_SW};

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; alucode = 6'd0; addr = 32'd0; st_data = 32'd0; rd = 5'd0;
        mem_if.mem_ack = 1'b0; mem_if.mem_rdata = 32'd0;
        nx_code = 6'd0; nx_addr = 32'd0; nx_st = 32'd0; nx_rd = 5'd0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state
        chk("rst_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_req", {31'd0, mem_if.mem_req}, 32'd0);
        chk("rst_we", {31'd0, mem_if.mem_we}, 32'd0);
        chk("rst_maddr", mem_if.mem_addr, 32'd0);
        chk("rst_be", {28'd0, mem_if.mem_be}, 32'd0);
        chk("rst_wdata", mem_if.mem_wdata, 32'd0);
        chk("rst_wbv", {31'd0, wb_valid}, 32'd0);
        chk("rst_wbdata", wb_data, 32'd0);
        chk("rst_wbrd", {27'd0, wb_rd}, 32'd0);
        chk("rst_std", {31'd0, st_done}, 32'd0);
`ifdef LSU_MISALIGN_TRAP_EN
        chk("rst_mis", {31'd0, misalign}, 32'd0);
`endif

        // Directed cases
        run_op(ALU_LW, 32'h100, 32'd0, 5'd5, 2, 32'hDEADBEEF, 1'b0);
        chk("tp_lw", wb_data, 32'hDEADBEEF);
        run_op(ALU_LB, 32'h103, 32'd0, 5'd6, 0, 32'h8000_0000, 1'b0);
        chk("tp_lb", wb_data, 32'hFFFF_FF80);
        run_op(ALU_LBU, 32'h103, 32'd0, 5'd6, 1, 32'h8000_0000, 1'b0);
        chk("tp_lbu", wb_data, 32'h0000_0080);
        run_op(ALU_SH, 32'h206, 32'h1234ABCD, 5'd0, 0, 32'd0, 1'b0);
        run_op(ALU_LW, 32'h102, 32'd0, 5'd9, 1, 32'hCAFE_F00D, 1'b0);
        run_op(ALU_LH, 32'h303, 32'd0, 5'd10, 0, 32'h8001_7FFE, 1'b0);

        // Back-to-back: LHU held upstream while SW is busy
        nx_code = ALU_LHU; nx_addr = 32'h40A; nx_st = 32'h5555_5555; nx_rd = 5'd7;
        run_op(ALU_SW, 32'h500, 32'h0BAD_F00D, 5'd3, 1, 32'd0, 1'b1);
        run_op(ALU_LHU, 32'h40A, 32'h5555_5555, 5'd7, 0, 32'hF00F_1234, 1'b0);

        // Non-memory alucode is ignored
        in_valid = 1'b1; alucode = ALU_ADD; addr = 32'h600;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("add_ready", {31'd0, in_ready}, 32'd1);
            chk("add_req", {31'd0, mem_if.mem_req}, 32'd0);
            chk("add_wbv", {31'd0, wb_valid}, 32'd0);
            chk("add_std", {31'd0, st_done}, 32'd0);
        end
        in_valid = 1'b0;

        // Reset in the middle of ACCESS, then a late ack in IDLE
        in_valid = 1'b1; alucode = ALU_LW; addr = 32'h300; rd = 5'd12;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("mid_req", {31'd0, mem_if.mem_req}, 32'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_wb_data = 32'd0; exp_wb_rd = 5'd0;
        chk("mid_req_drop", {31'd0, mem_if.mem_req}, 32'd0);
        chk("mid_ready", {31'd0, in_ready}, 32'd1);
        chk("mid_wbdata", wb_data, 32'd0);
        mem_if.mem_ack = 1'b1; mem_if.mem_rdata = 32'h1111_2222;
        @(posedge clk); #1;
        mem_if.mem_ack = 1'b0;
        chk("late_wbv", {31'd0, wb_valid}, 32'd0);
        chk("late_std", {31'd0, st_done}, 32'd0);
        chk("late_ready", {31'd0, in_ready}, 32'd1);
        chk("late_req", {31'd0, mem_if.mem_req}, 32'd0);

        // Random traffic
        for (int k = 0; k < 200; k++) begin
            run_op(codes[$urandom_range(0, 7)], $urandom, $urandom, 5'($urandom_range(0, 31)),
                   $urandom_range(0, 3), $urandom, 1'b0);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
